alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the core's combinational ALU.
- Supports signed add/sub, bitwise ops, and iterative signed multiply and divide behind a start/done handshake.
- Sits in the execute stage. The core's control unit issues one operation and stalls on busy until done.
- Flags (overflow, equals, above, zero) are well defined for every operation and hold until the next completion.

---
 rtl/alu_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle signed ALU with start/done handshake
//
// Single-cycle ADD/SUB/AND/OR/NOT/SLT, iterative MUL (shift-add) and DIV
// (restoring) on operand magnitudes, sign fixed up in a final cycle.
//
// Ports:
//   clock    rising-edge clock
//   reset    asynchronous active-high reset
//   start    operation request, sampled only while idle
//   func     000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 NOT, 111 SLT
//   op1      signed operand A
//   op2      signed operand B
//   busy     high while MUL/DIV iterate or fix up the sign
//   done     one-cycle pulse; result and flags valid from this cycle on
//   result   registered signed result
//   overflow arithmetic overflow or divide error
//   equals   op1 == op2 (SUB/SLT only)
//   above    op1 >  op2 signed (SUB/SLT only)
//   zero     result == 0

module alu_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       func,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             equals,
   output logic             above,
   output logic             zero
);

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

   localparam logic [2:0] F_ADD = 3'b000;
   localparam logic [2:0] F_SUB = 3'b001;
   localparam logic [2:0] F_MUL = 3'b010;
   localparam logic [2:0] F_DIV = 3'b011;
   localparam logic [2:0] F_AND = 3'b100;
   localparam logic [2:0] F_OR  = 3'b101;
   localparam logic [2:0] F_NOT = 3'b110;
   localparam logic [2:0] F_SLT = 3'b111;

   state_t state, state_next;

   // MUL: {partial product high half, multiplier shifting out to the right}
   // DIV: {remainder, dividend shifting out / quotient shifting in}
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opb_mag;
   logic               res_neg;
   logic               is_div;
   logic [CNT_W-1:0]   cnt;

   // single-cycle datapath
   logic [WIDTH-1:0] add_r, sub_r, quick_r;
   logic             quick_ovf, lt_c, eq_c, gt_c, cmp_valid;
   logic [WIDTH-1:0] op1_mag, op2_mag;

   always_comb begin
      add_r     = op1 + op2;
      sub_r     = op1 - op2;
      lt_c      = $signed(op1) < $signed(op2);
      gt_c      = $signed(op1) > $signed(op2);
      eq_c      = (op1 == op2);
      cmp_valid = (func == F_SUB) || (func == F_SLT);
      // -(-2^(W-1)) wraps to itself, which is the correct unsigned magnitude
      op1_mag   = op1[WIDTH-1] ? -op1 : op1;
      op2_mag   = op2[WIDTH-1] ? -op2 : op2;
      quick_r   = '0;
      quick_ovf = 1'b0;
      case (func)
         F_ADD: begin
            quick_r   = add_r;
            quick_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) && (add_r[WIDTH-1] != op1[WIDTH-1]);
         end
         F_SUB: begin
            quick_r   = sub_r;
            quick_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) && (sub_r[WIDTH-1] != op1[WIDTH-1]);
         end
         F_AND:   quick_r = op1 & op2;
         F_OR:    quick_r = op1 | op2;
         F_NOT:   quick_r = ~op1;
         F_SLT:   quick_r = {{(WIDTH-1){1'b0}}, lt_c};
         default: quick_r = '0;
      endcase
   end

   // one iteration step
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] step;

   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb_mag} : '0);
      // remainder stays below the divisor magnitude, so its top bit is never needed
      div_shift = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {1'b0, opb_mag};
      if (is_div) begin
         if (div_diff[WIDTH])
            step = {div_shift, acc[WIDTH-2:0], 1'b0};
         else
            step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         step = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   // sign fix-up
   logic [WIDTH-1:0] fix_r;
   logic             mul_ovf, div_ovf, fix_ovf;

   always_comb begin
      fix_r   = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      // a negative product may reach exactly 2^(W-1) in magnitude
      mul_ovf = res_neg ? ((|acc[2*WIDTH-1:WIDTH]) || (acc[WIDTH-1] && (|acc[WIDTH-2:0])))
                        : (|acc[2*WIDTH-1:WIDTH-1]);
      // only -2^(W-1) / -1 yields a positive quotient of 2^(W-1)
      div_ovf = !res_neg && acc[WIDTH-1];
      fix_ovf = is_div ? div_ovf : mul_ovf;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if ((func == F_MUL) || ((func == F_DIV) && (op2 != '0)))
                  state_next = ITER;
               else
                  state_next = DONE;
            end
         end
         ITER: begin
            busy = 1'b1;
            if (cnt == CNT_W'(WIDTH-1))
               state_next = FIX;
         end
         FIX: begin
            busy       = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc      <= '0;
         opb_mag  <= '0;
         res_neg  <= 1'b0;
         is_div   <= 1'b0;
         cnt      <= '0;
         result   <= '0;
         overflow <= 1'b0;
         equals   <= 1'b0;
         above    <= 1'b0;
         zero     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if ((func == F_DIV) && (op2 == '0)) begin
                     result   <= '0;
                     overflow <= 1'b1;
                     equals   <= 1'b0;
                     above    <= 1'b0;
                     zero     <= 1'b1;
                  end else if ((func == F_MUL) || (func == F_DIV)) begin
                     acc     <= {{WIDTH{1'b0}}, op1_mag};
                     opb_mag <= op2_mag;
                     res_neg <= op1[WIDTH-1] ^ op2[WIDTH-1];
                     is_div  <= (func == F_DIV);
                     cnt     <= '0;
                  end else begin
                     result   <= quick_r;
                     overflow <= quick_ovf;
                     equals   <= cmp_valid && eq_c;
                     above    <= cmp_valid && gt_c;
                     zero     <= (quick_r == '0);
                  end
               end
            end
            ITER: begin
               acc <= step;
               cnt <= cnt + CNT_W'(1);
            end
            FIX: begin
               result   <= fix_r;
               overflow <= fix_ovf;
               equals   <= 1'b0;
               above    <= 1'b0;
               zero     <= (fix_r == '0);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH=32 and WIDTH=8

module tb_alu_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst32, start32, busy32, done32, ovf32, eq32, ab32, zero32;
   logic [2:0]  func32;
   logic [31:0] a32, b32, res32;
   logic        rst8, start8, busy8, done8, ovf8, eq8, ab8, zero8;
   logic [2:0]  func8;
   logic [7:0]  a8, b8, res8;

   int ncmp = 0;
   int nfail = 0;

   alu_seq #(.WIDTH(32), .CNT_W(6)) dut32 (
      .clock(clk), .reset(rst32), .start(start32), .func(func32), .op1(a32), .op2(b32),
      .busy(busy32), .done(done32), .result(res32), .overflow(ovf32), .equals(eq32),
      .above(ab32), .zero(zero32)
   );

   alu_seq #(.WIDTH(8), .CNT_W(4)) dut8 (
      .clock(clk), .reset(rst8), .start(start8), .func(func8), .op1(a8), .op2(b8),
      .busy(busy8), .done(done8), .result(res8), .overflow(ovf8), .equals(eq8),
      .above(ab8), .zero(zero8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain signed integer arithmetic, then range test / truncation.
   function automatic void model(input int w, input logic [2:0] f, input logic [63:0] a,
                                 input logic [63:0] b, output logic [63:0] r, output logic ov,
                                 output logic eq, output logic ab, output logic z, output int lat);
      longint sa, sb, v, mx, mn;
      logic [63:0] m;
      m  = (64'd1 << w) - 64'd1;
      sa = longint'(a << (64 - w)) >>> (64 - w);
      sb = longint'(b << (64 - w)) >>> (64 - w);
      mx = (longint'(1) << (w - 1)) - 1;
      mn = -mx - 1;
      ov = 1'b0; eq = 1'b0; ab = 1'b0; lat = 1; v = 0;
      case (f)
         3'd0: begin v = sa + sb; ov = (v > mx) || (v < mn); end
         3'd1: begin v = sa - sb; ov = (v > mx) || (v < mn); eq = (sa == sb); ab = (sa > sb); end
         3'd2: begin v = sa * sb; ov = (v > mx) || (v < mn); lat = w + 2; end
         3'd3: begin
            if (sb == 0) begin v = 0; ov = 1'b1; end
            else begin v = sa / sb; ov = (v > mx) || (v < mn); lat = w + 2; end
         end
         3'd4: v = longint'(a & b);
         3'd5: v = longint'(a | b);
         3'd6: v = longint'(~a);
         default: begin v = (sa < sb) ? 1 : 0; eq = (sa == sb); ab = (sa > sb); end
      endcase
      r = 64'(v) & m;
      z = (r == 64'd0);
   endfunction

   task automatic run32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] er; logic eo, ee, ea, ez; int el, lat;
      model(32, f, {32'd0, a}, {32'd0, b}, er, eo, ee, ea, ez, el);
      @(negedge clk);
      func32 = f; a32 = a; b32 = b; start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0; a32 = $urandom; b32 = $urandom; func32 = 3'($urandom);
      check($sformatf("busy32 f%0d", f), {63'd0, busy32}, {63'd0, el > 1});
      lat = 1;
      while (done32 !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
      check($sformatf("lat32 f%0d", f), 64'(lat), 64'(el));
      check($sformatf("res32 f%0d %h,%h", f, a, b), {32'd0, res32}, er);
      check($sformatf("ovf32 f%0d", f), {63'd0, ovf32}, {63'd0, eo});
      check($sformatf("eq32 f%0d", f), {63'd0, eq32}, {63'd0, ee});
      check($sformatf("ab32 f%0d", f), {63'd0, ab32}, {63'd0, ea});
      check($sformatf("zero32 f%0d", f), {63'd0, zero32}, {63'd0, ez});
   endtask

   task automatic run8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
      logic [63:0] er; logic eo, ee, ea, ez; int el, lat;
      model(8, f, {56'd0, a}, {56'd0, b}, er, eo, ee, ea, ez, el);
      @(negedge clk);
      func8 = f; a8 = a; b8 = b; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); func8 = 3'($urandom);
      lat = 1;
      while (done8 !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
      check($sformatf("lat8 f%0d", f), 64'(lat), 64'(el));
      check($sformatf("res8 f%0d %h,%h", f, a, b), {56'd0, res8}, er);
      check($sformatf("ovf8 f%0d", f), {63'd0, ovf8}, {63'd0, eo});
      check($sformatf("eq8 f%0d", f), {63'd0, eq8}, {63'd0, ee});
      check($sformatf("ab8 f%0d", f), {63'd0, ab8}, {63'd0, ea});
      check($sformatf("zero8 f%0d", f), {63'd0, zero8}, {63'd0, ez});
   endtask

   initial begin
      logic [63:0] er; logic eo, ee, ea, ez; int el, ndone, nbusy;
      logic [2:0] f; logic [31:0] a, b; logic [7:0] c, d;
      logic [7:0] edge8 [4];
      edge8 = '{8'h80, 8'h7F, 8'hFF, 8'h01};

      rst32 = 1'b1; rst8 = 1'b1; start32 = 1'b0; start8 = 1'b0;
      func32 = '0; func8 = '0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
      repeat (2) @(negedge clk);
      check("reset busy", {63'd0, busy32}, 64'd0);
      check("reset done", {63'd0, done32}, 64'd0);
      check("reset result", {32'd0, res32}, 64'd0);
      check("reset flags", {60'd0, ovf32, eq32, ab32, zero32}, 64'd0);
      rst32 = 1'b0; rst8 = 1'b0;

      // directed WIDTH=32 cases
      run32(3'd1, 32'd5, 32'd5);
      run32(3'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      run32(3'd2, -32'sd7, 32'd6);
      check("mul -7*6 const", {32'd0, res32}, {32'd0, 32'hFFFF_FFD6});
      run32(3'd2, 32'h0001_0000, 32'h0001_0000);
      run32(3'd3, -32'sd7, 32'd2);
      check("div -7/2 const", {32'd0, res32}, {32'd0, 32'hFFFF_FFFD});
      run32(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      run32(3'd3, 32'd9, 32'd0);
      run32(3'd6, 32'hFFFF_FFFF, 32'd0);
      run32(3'd7, 32'hFFFF_FFFF, 32'd1);
      run32(3'd2, 32'h8000_0000, 32'd1);
      run32(3'd2, 32'hFFFF_0000, 32'h0000_8000);

      // handshake: start held high, inputs churn while busy and during done
      model(32, 3'd2, 64'd1234, 64'hFFFF_FFFF_FFFF_FF85, er, eo, ee, ea, ez, el);
      @(negedge clk);
      func32 = 3'd2; a32 = 32'd1234; b32 = 32'hFFFF_FF85; start32 = 1'b1;
      ndone = 0; nbusy = 0;
      for (int i = 0; i < 34; i++) begin
         @(negedge clk);
         if (done32 === 1'b1) ndone++;
         if (busy32 === 1'b1) nbusy++;
         a32 = $urandom; b32 = $urandom; func32 = 3'($urandom);
      end
      check("hs done pulses", 64'(ndone), 64'd1);
      check("hs busy cycles", 64'(nbusy), 64'd33);
      check("hs done at 34", {63'd0, done32}, 64'd1);
      check("hs result", {32'd0, res32}, er);
      @(negedge clk);
      check("hs start in done ignored", {62'd0, busy32, done32}, 64'd0);
      start32 = 1'b0;

      // async reset in the middle of a MUL (counter = 10)
      run32(3'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      @(negedge clk);
      func32 = 3'd2; a32 = -32'sd7; b32 = 32'd6; start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst32 = 1'b1;
      #1;
      check("async rst busy", {63'd0, busy32}, 64'd0);
      check("async rst done", {63'd0, done32}, 64'd0);
      check("async rst result", {32'd0, res32}, 64'd0);
      check("async rst flags", {60'd0, ovf32, eq32, ab32, zero32}, 64'd0);
      @(negedge clk);
      rst32 = 1'b0;
      run32(3'd0, 32'd3, 32'd4);
      check("add 3+4 const", {32'd0, res32}, 64'd7);

      // random WIDTH=32
      for (int i = 0; i < 30; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($signed(b) >>> 24);
         if (f == 3'd3 && $urandom_range(0, 5) == 0) b = '0;
         run32(f, a, b);
      end

      // WIDTH=8
      run8(3'd0, 8'h7F, 8'h01);
      run8(3'd2, 8'hF9, 8'h06);
      run8(3'd2, 8'h10, 8'h10);
      run8(3'd3, 8'h80, 8'hFF);
      run8(3'd3, 8'hF9, 8'h02);
      run8(3'd3, 8'h09, 8'h00);
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7));
         c = ($urandom_range(0, 3) == 0) ? edge8[$urandom_range(0, 3)] : 8'($urandom);
         d = ($urandom_range(0, 3) == 0) ? edge8[$urandom_range(0, 3)] : 8'($urandom);
         if (f == 3'd3 && $urandom_range(0, 5) == 0) d = '0;
         run8(f, c, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
